// File: rtl/crc32_check_pkg.sv
// Shared CRC32 constants and the byte-wise update used by both the generator
// and the checker, so the two ends of the link stay bit-identical.
package crc32_check_pkg;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    localparam int DLY_BYTES = 4;

    // Reflected CRC32, one byte, LSB first; no final xor (the checker relies on the residue)
    function automatic logic [31:0] crc32_next8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_check_if.sv
// Byte stream in, stripped payload stream plus per-frame check report out.
interface crc32_check_if #(
    parameter int LEN_W = 16
);
    import crc32_check_pkg::*;

    // Valid-only streams: a byte transfers on every cycle its valid is high;
    // there is no ready, so the consumer must take out_data whenever out_valid is set.
    // *_last qualifies valid; the report fields qualify crc_done.
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_last;
    logic             crc_done;
    logic             crc_ok;
    logic             runt;
    logic             len_ovf;
    logic [LEN_W-1:0] frame_len;
    logic [0:0]       dbg_state;

    modport master (
        output in_data, in_valid, in_last,
        input  out_data, out_valid, out_last,
        input  crc_done, crc_ok, runt, len_ovf, frame_len, dbg_state
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output out_data, out_valid, out_last,
        output crc_done, crc_ok, runt, len_ovf, frame_len, dbg_state
    );

endinterface

// File: rtl/crc32_check.sv
// Receive-side CRC32 checker: strips the trailing 4-byte FCS through a delay
// line, forwards the payload and reports pass/fail and length per frame.
module crc32_check
    import crc32_check_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input logic          clk,
    input logic          rst,
    crc32_check_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [0:0]             state_q;
    logic [31:0]            crc_q;
    logic [DLY_BYTES-1:0][7:0] dline_q;
    logic [2:0]             fill_q;
    logic [LEN_W-1:0]       len_q;
    logic                   ovf_q;

    logic [31:0]      crc_next;
    logic             emit;
    logic             end_frame;
    logic [LEN_W-1:0] len_next;
    logic             ovf_next;

    // The line only gives up its oldest byte once four newer ones exist,
    // which is exactly what keeps the FCS from ever reaching the output.
    always_comb begin
        crc_next  = crc32_next8(crc_q, bus.in_data);
        emit      = bus.in_valid && (fill_q == 3'(DLY_BYTES));
        end_frame = bus.in_valid && bus.in_last;
        len_next  = len_q;
        ovf_next  = ovf_q;
        if (emit) begin
            if (len_q == LEN_MAX) begin
                ovf_next = 1'b1;
            end else begin
                len_next = len_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            crc_q         <= CRC_INIT;
            dline_q       <= '0;
            fill_q        <= '0;
            len_q         <= '0;
            ovf_q         <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.crc_done  <= 1'b0;
            bus.crc_ok    <= 1'b0;
            bus.runt      <= 1'b0;
            bus.len_ovf   <= 1'b0;
            bus.frame_len <= '0;
        end else begin
            bus.out_valid <= emit;
            bus.out_last  <= emit && bus.in_last;
            if (emit) begin
                bus.out_data <= dline_q[DLY_BYTES-1];
            end

            // Report fields are only meaningful alongside crc_done; zero otherwise.
            bus.crc_done  <= end_frame;
            bus.crc_ok    <= end_frame && emit && (crc_next == CRC_RESIDUE);
            bus.runt      <= end_frame && !emit;
            bus.len_ovf   <= end_frame && ovf_next;
            bus.frame_len <= end_frame ? len_next : '0;

            if (bus.in_valid) begin
                dline_q <= {dline_q[DLY_BYTES-2:0], bus.in_data};
                if (end_frame) begin
                    // Reinit so the next frame's first byte can land next cycle.
                    state_q <= ST_IDLE;
                    crc_q   <= CRC_INIT;
                    fill_q  <= '0;
                    len_q   <= '0;
                    ovf_q   <= 1'b0;
                end else begin
                    state_q <= ST_RECV;
                    crc_q   <= crc_next;
                    fill_q  <= emit ? fill_q : fill_q + 3'd1;
                    len_q   <= len_next;
                    ovf_q   <= ovf_next;
                end
            end
        end
    end

    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_crc32_check.sv
// Self-checking bench for crc32_check: frame-level reference model, random gaps/payloads.
module tb_crc32_check;
    import crc32_check_pkg::*;

    localparam int LEN_W   = 4;
    localparam int LEN_MAX = (1 << LEN_W) - 1;
    localparam int RW      = LEN_W + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc32_check_if #(.LEN_W(LEN_W)) bus ();
    crc32_check #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Scoreboard: payload entries are {last, data}; reports are {out_last, ok, runt, ovf, len}
    logic [8:0]    exp_q[$];
    logic [8:0]    got_q[$];
    logic [RW-1:0] exp_rep_q[$];
    logic [RW-1:0] got_rep_q[$];
    logic [7:0]    frame[$];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) got_q.push_back({bus.out_last, bus.out_data});
        if (bus.crc_done === 1'b1)
            got_rep_q.push_back({bus.out_last, bus.crc_ok, bus.runt, bus.len_ovf, bus.frame_len});
    end

    // Standard CRC32 of the payload (init all-ones, final inversion)
    function automatic logic [31:0] ref_crc(input int cnt);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < cnt; i++) begin
            c ^= {24'd0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Frame is good when the 4 trailing bytes, LSB first, equal the payload CRC.
    function automatic void model_frame();
        int n = frame.size();
        int pl = (n >= 5) ? n - 4 : 0;
        logic ok = 1'b0;
        logic ovf = (pl > LEN_MAX);
        int len = ovf ? LEN_MAX : pl;
        for (int i = 0; i < pl; i++) exp_q.push_back({1'(i == pl - 1), frame[i]});
        if (n >= 5) ok = ({frame[n-1], frame[n-2], frame[n-3], frame[n-4]} == ref_crc(pl));
        exp_rep_q.push_back({1'(pl > 0), ok, 1'(n < 5), ovf, LEN_W'(len)});
    endfunction

    function automatic void make_frame(input int pl, input bit corrupt);
        logic [31:0] c;
        frame.delete();
        for (int i = 0; i < pl; i++) frame.push_back(8'($urandom));
        c = ref_crc(pl);
        for (int i = 0; i < 4; i++) frame.push_back(c[8*i +: 8]);
        if (corrupt) frame[$urandom_range(frame.size() - 1)] ^= 8'(1 << $urandom_range(7));
    endfunction

    function automatic void clear_sb();
        exp_q.delete(); got_q.delete(); exp_rep_q.delete(); got_rep_q.delete();
    endfunction

    // Gap cycles toggle in_last randomly to show it is ignored without in_valid.
    task automatic drive_bytes(input int first, input int count, input int gap_pct);
        for (int i = first; i < first + count; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0; bus.in_last = 1'($urandom); bus.in_data = 8'($urandom);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b1; bus.in_data = frame[i]; bus.in_last = (i == frame.size() - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0; bus.in_last = 1'b0;
        end
    endtask

    task automatic load_good();
        frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
    endtask

    task automatic compare_all(input string tag);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_nbytes got %0d exp %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL %s_byte%0d got %h exp %h", tag, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_rep_q.size() != exp_rep_q.size()) begin
            errors++; $display("FAIL %s_nreports got %0d exp %0d", tag, got_rep_q.size(), exp_rep_q.size());
        end
        for (int i = 0; i < exp_rep_q.size() && i < got_rep_q.size(); i++) begin
            checks++;
            if (got_rep_q[i] !== exp_rep_q[i]) begin
                errors++; $display("FAIL %s_report%0d got %h exp %h", tag, i, got_rep_q[i], exp_rep_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.out_data, bus.out_valid, bus.out_last, bus.crc_done, bus.crc_ok, bus.runt,
             bus.len_ovf, bus.frame_len, bus.dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b l=%b d=%b ok=%b r=%b o=%b len=%0d st=%b exp all 0",
                     bus.out_data, bus.out_valid, bus.out_last, bus.crc_done, bus.crc_ok, bus.runt,
                     bus.len_ovf, bus.frame_len, bus.dbg_state);
        end
    endtask

    task automatic test_known_good();
        clear_sb(); load_good(); model_frame();
        drive_bytes(0, frame.size(), 0); idle(4);
        compare_all("good");
        checks++;
        if (got_rep_q.size() < 1 || got_rep_q[0] !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd9}) begin
            errors++; $display("FAIL good_literal got %h exp %h",
                               (got_rep_q.size() > 0) ? got_rep_q[0] : '0, {4'b1100, 4'd9});
        end
    endtask

    task automatic test_bad_fcs();
        clear_sb(); load_good(); frame[12] = 8'hCA; model_frame();
        drive_bytes(0, frame.size(), 0); idle(4);
        compare_all("badfcs");
    endtask

    task automatic test_gaps();
        clear_sb(); load_good(); model_frame();
        drive_bytes(0, frame.size(), 40); idle(4);
        compare_all("gaps");
    endtask

    task automatic test_back_to_back();
        clear_sb();
        load_good(); model_frame(); drive_bytes(0, frame.size(), 0);
        make_frame(7, 1'b0); model_frame(); drive_bytes(0, frame.size(), 0);
        idle(4);
        compare_all("b2b");
    endtask

    task automatic test_short_frames();
        clear_sb();
        frame = '{8'hAA, 8'hBB, 8'hCC}; model_frame(); drive_bytes(0, 3, 0); idle(3);
        make_frame(0, 1'b0); model_frame(); drive_bytes(0, 4, 0); idle(3);
        make_frame(1, 1'b0); model_frame(); drive_bytes(0, 5, 0); idle(3);
        frame = '{8'h5A}; model_frame(); drive_bytes(0, 1, 0); idle(3);
        compare_all("short");
    endtask

    task automatic test_len_sat();
        clear_sb();
        make_frame(LEN_MAX, 1'b0); model_frame(); drive_bytes(0, frame.size(), 0);
        make_frame(LEN_MAX + 1, 1'b0); model_frame(); drive_bytes(0, frame.size(), 10);
        make_frame(LEN_MAX + 9, 1'b1); model_frame(); drive_bytes(0, frame.size(), 0);
        idle(4);
        compare_all("lensat");
    endtask

    task automatic test_mid_reset();
        clear_sb();
        make_frame(9, 1'b0);
        // Six bytes pushed: the first two payload bytes legitimately leave before the abort.
        exp_q.push_back({1'b0, frame[0]});
        exp_q.push_back({1'b0, frame[1]});
        drive_bytes(0, 6, 0);
        @(posedge clk); #1; rst = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        load_good(); model_frame(); drive_bytes(0, frame.size(), 0); idle(4);
        compare_all("midrst");
    endtask

    task automatic test_random();
        clear_sb();
        for (int f = 0; f < 25; f++) begin
            make_frame($urandom_range(24), 1'($urandom_range(2) == 0));
            model_frame();
            drive_bytes(0, frame.size(), $urandom_range(50));
            if ($urandom_range(1) == 1) idle($urandom_range(3));
        end
        idle(4);
        compare_all("random");
    endtask

    initial begin
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_known_good();
        test_bad_fcs();
        test_gaps();
        test_back_to_back();
        test_short_frames();
        test_len_sat();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
